// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter: default oversampling ratio,
// transmitter FSM state encoding and a helper giving the frame length in clk
// cycles for a given parameter set.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default number of clk cycles per bit period.
    localparam int OVERSAMPLE_DFLT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Total clk cycles occupied by one frame:
    // start + 8 data + optional parity + stop bits.
    function automatic int frame_cycles(input int oversample,
                                        input int parity_en,
                                        input int stop_bits);
        return oversample * (9 + parity_en + stop_bits);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous byte FIFO between the host write port and the serialiser.
// Pointers carry one extra wrap bit so full and empty are distinguished
// without a separate occupancy counter.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous reset, active-high (empties the FIFO)
//   push   in   write request; ignored while full
//   wdata  in   byte to write
//   pop    in   read request; ignored while empty
//   rdata  out  head of the FIFO (valid while !empty)
//   full   out  no free entry
//   empty  out  no stored entry
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        do_push;
    logic        do_pop;

    // A push while full is dropped even if a pop happens on the same edge,
    // so full never depends on the pop request.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit and
// one or two stop bits, each bit held OVERSAMPLE clk cycles. A small byte
// FIFO decouples the host valid/ready port; queued bytes go out back-to-back.
//
// Ports
//   clk        in   system clock (OVERSAMPLE x bit rate)
//   rst        in   synchronous reset, active-high; aborts any frame in flight
//   din        in   byte to send
//   din_valid  in   din is presented
//   din_ready  out  FIFO not full; byte accepted when din_valid & din_ready
//   tx         out  serial line, idles high
//   busy       out  transmitter FSM not idle
//   frame_done out  one-cycle pulse during the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DFLT,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int              TC_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TC_W-1:0] TC_END    = TC_W'(OVERSAMPLE - 1);
    localparam logic [TC_W-1:0] TC_PRE    = TC_W'(OVERSAMPLE - 2);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t       state;
    tx_state_t       state_nx;
    logic [TC_W-1:0] tc;
    logic [TC_W-1:0] tc_nx;
    logic [2:0]      bi;
    logic [2:0]      bi_nx;
    logic [2:0]      bi_inc;
    logic            end_tick;
    logic            tx_nx;
    logic            fd_nx;
    logic            pop;
    logic [7:0]      sh;
    logic            par;
    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (din_valid),
        .wdata (din),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign din_ready = !fifo_full;
    assign busy      = (state != IDLE);
    assign end_tick  = (tc == TC_END);
    assign bi_inc    = bi + 3'd1;

    // Next-state logic. tx and frame_done are computed one cycle ahead so
    // that both leave the module straight from flops. In STOP, bi is reused
    // to count stop bits.
    always_comb begin
        state_nx = state;
        tc_nx    = tc;
        bi_nx    = bi;
        tx_nx    = tx;
        fd_nx    = 1'b0;
        pop      = 1'b0;

        unique case (state)
            IDLE: begin
                tc_nx = '0;
                bi_nx = '0;
                tx_nx = 1'b1;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    tx_nx    = 1'b0;
                    state_nx = START;
                end
            end

            START: begin
                if (end_tick) begin
                    tc_nx    = '0;
                    bi_nx    = '0;
                    tx_nx    = sh[0];
                    state_nx = DATA;
                end else begin
                    tc_nx = tc + 1'b1;
                end
            end

            DATA: begin
                if (end_tick) begin
                    tc_nx = '0;
                    if (bi == 3'd7) begin
                        bi_nx = '0;
                        if (PARITY_EN != 0) begin
                            tx_nx    = par;
                            state_nx = PARITY;
                        end else begin
                            tx_nx    = 1'b1;
                            state_nx = STOP;
                        end
                    end else begin
                        bi_nx = bi_inc;
                        tx_nx = sh[bi_inc];
                    end
                end else begin
                    tc_nx = tc + 1'b1;
                end
            end

            PARITY: begin
                if (end_tick) begin
                    tc_nx    = '0;
                    bi_nx    = '0;
                    tx_nx    = 1'b1;
                    state_nx = STOP;
                end else begin
                    tc_nx = tc + 1'b1;
                end
            end

            STOP: begin
                // Raise frame_done so it is high during the final stop cycle.
                fd_nx = (bi == STOP_LAST) && (tc == TC_PRE);
                if (end_tick) begin
                    tc_nx = '0;
                    if (bi == STOP_LAST) begin
                        bi_nx = '0;
                        if (!fifo_empty) begin
                            pop      = 1'b1;
                            tx_nx    = 1'b0;
                            state_nx = START;
                        end else begin
                            tx_nx    = 1'b1;
                            state_nx = IDLE;
                        end
                    end else begin
                        bi_nx = bi_inc;
                    end
                end else begin
                    tc_nx = tc + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                tc_nx    = '0;
                bi_nx    = '0;
                tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tc         <= '0;
            bi         <= '0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            tc         <= tc_nx;
            bi         <= bi_nx;
            tx         <= tx_nx;
            frame_done <= fd_nx;
        end
    end

    // Shift register and parity are captured when a byte leaves the FIFO,
    // so later FIFO traffic cannot disturb the frame in flight.
    always_ff @(posedge clk) begin
        if (pop) begin
            sh  <= fifo_rdata;
            par <= PARITY_MODE[0] ^ (^fifo_rdata);
        end
    end

endmodule
